// File: rtl/logic_func_pipe_if.sv
// Operand/result handshake bundle for logic_func_pipe.
// master = producer/consumer side, slave = the function block.
interface logic_func_pipe_if #(
    parameter int WIDTH = 8
);
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [15:0]      xfer_count;

    modport master (
        output sel, in_valid, a, b, c, d, e, f, g, h, out_ready,
        input  in_ready, out_valid, y, xfer_count
    );

    modport slave (
        input  sel, in_valid, a, b, c, d, e, f, g, h, out_ready,
        output in_ready, out_valid, y, xfer_count
    );
endinterface

// File: rtl/logic_func_pipe.sv
// Bitwise 8-input boolean function with run-time bypass or DEPTH-stage valid/ready pipeline.
// Optional output-handshake counter enabled by defining LFP_COUNT_EN.
module logic_func_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    logic_func_pipe_if.slave bus
);
    logic [WIDTH-1:0] fn;
    logic [DEPTH-1:0] v_reg;
    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             busy;
    logic             pipe_path;
    logic             accept;

    assign fn = (((bus.a & bus.b) | (bus.c ^ bus.d)) & (~bus.e | bus.f)) ^ (bus.g & ~bus.h);

    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~v_reg[k] | rdy[k+1];
        end
    end

    assign busy      = |v_reg;
    assign pipe_path = busy | bus.sel;
    // With sel low a non-empty pipeline refuses input so it drains before bypass resumes.
    assign bus.in_ready  = bus.sel ? rdy[0] : (~busy & bus.out_ready);
    assign accept        = bus.sel & bus.in_valid & rdy[0];
    assign bus.out_valid = pipe_path ? v_reg[DEPTH-1] : bus.in_valid;
    assign bus.y         = !bus.out_valid ? '0 :
                           (pipe_path ? data_reg[DEPTH-1] : fn);

    // Stage k reloads whenever it is empty or its content is moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_reg[0] <= accept;
                if (accept) begin
                    data_reg[0] <= fn;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_reg[k]    <= v_reg[k-1];
                    data_reg[k] <= data_reg[k-1];
                end
            end
        end
    end

`ifdef LFP_COUNT_EN
    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (bus.out_valid && bus.out_ready && count_reg != 16'hFFFF) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign bus.xfer_count = count_reg;
`else
    assign bus.xfer_count = 16'h0000;
`endif
endmodule

// File: tb/tb_logic_func_pipe.sv
// Directed bench for logic_func_pipe (WIDTH=8, DEPTH=2): table-driven bypass vectors
// plus hand-written pipeline, stall, mode-change and reset sequences.
module tb_logic_func_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic_func_pipe_if #(.WIDTH(8)) bus ();

    logic_func_pipe #(.WIDTH(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] a, b, c, d, e, f, g, h;
        logic [7:0] y;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    int checks  = 0;
    int passes  = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic drive(input int i, input logic valid);
        bus.a = vt[i].a; bus.b = vt[i].b; bus.c = vt[i].c; bus.d = vt[i].d;
        bus.e = vt[i].e; bus.f = vt[i].f; bus.g = vt[i].g; bus.h = vt[i].h;
        bus.in_valid = valid;
    endtask

    function automatic logic [15:0] cnt_exp();
`ifdef LFP_COUNT_EN
        return 16'(exp_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    // Settle, compare the three handshake-side outputs, then advance one clock.
    task automatic observe(input string tag, input logic eir, input logic eov, input logic [7:0] ey);
        #1;
        chk({tag, ".in_ready"},  bus.in_ready,  eir);
        chk({tag, ".out_valid"}, bus.out_valid, eov);
        chk({tag, ".y"},         bus.y,         ey);
        $display("txn %s: in_valid=%0b in_ready=%0b out_valid=%0b y=%02h", tag,
                 bus.in_valid, bus.in_ready, bus.out_valid, bus.y);
        if (eov && bus.out_ready) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h30, 8'hCF};
        vt[1] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hF0, 8'h30, 8'hC0};
        vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[3] = '{8'h00, 8'h00, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        vt[4] = '{8'hF0, 8'h3C, 8'h0F, 8'h0F, 8'hF0, 8'h30, 8'h00, 8'h00, 8'h30};
        vt[5] = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hD9};
        vt[6] = '{8'h00, 8'h00, 8'h81, 8'h00, 8'h0F, 8'h01, 8'hFF, 8'hFF, 8'h81};

        // Reset state
        rst = 1'b1; bus.sel = 1'b0; bus.out_ready = 1'b1;
        drive(2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.y", bus.y, 8'h00);
        chk("rst.in_ready_sel0", bus.in_ready, 1'b1);
        chk("rst.xfer_count", bus.xfer_count, 16'h0000);
        bus.sel = 1'b1; bus.out_ready = 1'b0;
        #1;
        chk("rst.in_ready_sel1", bus.in_ready, 1'b1);
        bus.sel = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Bypass: table applied combinationally
        for (int i = 0; i < NV; i++) begin
            drive(i, 1'b1);
            observe($sformatf("byp%0d", i), 1'b1, 1'b1, vt[i].y);
        end
        bus.out_ready = 1'b0;
        drive(0, 1'b1);
        observe("byp_stall", 1'b0, 1'b1, 8'hCF);
        bus.out_ready = 1'b1;
        drive(0, 1'b0);
        observe("byp_idle", 1'b1, 1'b0, 8'h00);
        chk("cnt_bypass", bus.xfer_count, cnt_exp());

        // Pipelined back-to-back, no stall: 2-cycle latency, full throughput
        bus.sel = 1'b1;
        for (int t = 0; t < 7; t++) begin
            logic       ev;
            logic [7:0] ey;
            ev = (t >= 2 && t < 6);
            ey = ev ? vt[t-2].y : 8'h00;
            if (t < 4) drive(t, 1'b1);
            else       bus.in_valid = 1'b0;
            observe($sformatf("pipe%0d", t), 1'b1, ev, ey);
        end

        // Stall: two accepted, third refused, then simultaneous accept and drain
        bus.out_ready = 1'b0;
        drive(0, 1'b1); observe("stall0", 1'b1, 1'b0, 8'h00);
        drive(1, 1'b1); observe("stall1", 1'b1, 1'b0, 8'h00);
        drive(2, 1'b1); observe("stall2", 1'b0, 1'b1, vt[0].y);
        observe("stall3", 1'b0, 1'b1, vt[0].y);
        bus.out_ready = 1'b1;
        observe("drain0", 1'b1, 1'b1, vt[0].y);
        bus.in_valid = 1'b0;
        observe("drain1", 1'b1, 1'b1, vt[1].y);
        observe("drain2", 1'b1, 1'b1, vt[2].y);
        observe("drain3", 1'b1, 1'b0, 8'h00);

        // Mode change with two results in flight
        drive(3, 1'b1); observe("mode0", 1'b1, 1'b0, 8'h00);
        drive(4, 1'b1); observe("mode1", 1'b1, 1'b0, 8'h00);
        bus.sel = 1'b0;
        drive(5, 1'b1); observe("mode2", 1'b0, 1'b1, vt[3].y);
        observe("mode3", 1'b0, 1'b1, vt[4].y);
        observe("mode4_byp", 1'b1, 1'b1, vt[5].y);
        bus.in_valid = 1'b0;
        chk("cnt_total", bus.xfer_count, cnt_exp());

        // Reset with a full pipeline discards everything
        bus.sel = 1'b1; bus.out_ready = 1'b0;
        drive(0, 1'b1); observe("fill0", 1'b1, 1'b0, 8'h00);
        drive(1, 1'b1); observe("fill1", 1'b1, 1'b0, 8'h00);
        drive(2, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt = 0;
        #1;
        chk("mrst.out_valid", bus.out_valid, 1'b0);
        chk("mrst.y", bus.y, 8'h00);
        chk("mrst.xfer_count", bus.xfer_count, cnt_exp());
        chk("mrst.in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        observe("mrst_after", 1'b1, 1'b0, 8'h00);
        observe("mrst_after2", 1'b1, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/logic_func_pipe.md
# logic_func_pipe

- Parametrised, handshaked successor of the team's single-bit 8-input combinational/registered function block.
- Evaluates the same fixed boolean function bitwise across WIDTH-bit operand vectors.
- Output is either a combinational bypass or a DEPTH-stage valid/ready pipeline with backpressure, selected at run time.
- Sits between an operand producer and a result consumer that may stall; ordering is preserved across mode changes.

## Interface
Parameters:
- WIDTH, 8, lane count; operand and result width (1..64)
- DEPTH, 2, pipeline stages in registered mode (1..4)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- sel  in  1  mode request: 0 = combinational bypass, 1 = pipelined
- in_valid  in  1  operand set valid
- in_ready  out  1  block accepts operands this cycle
- a, b, c, d, e, f, g, h  in  WIDTH each  operand vectors
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- xfer_count  out  16  completed output handshakes (see Configuration)

## Operation
- Function per bit i, using Verilog precedence as written: y[i] = (((a&b) | (c^d)) & (~e|f)) ^ (g&~h).
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Pipeline: stages s0..s(DEPTH-1), each holding a valid bit and a WIDTH-bit data register.
  - s0 loads the computed function on an input handshake taken on the pipeline path.
  - ready chain: rdy[k] = !v[k] | rdy[k+1], with rdy[DEPTH] = out_ready.
  - A stage advances when rdy[k+1] is high; otherwise it holds its data (no loss, no duplication).
- Path selection:
  - Any stage valid (pipeline non-empty): pipeline path. out_valid = v[DEPTH-1], y = data[DEPTH-1].
    - sel=1: in_ready = rdy[0].
    - sel=0: in_ready = 0, so the pipeline drains before bypass resumes.
  - Pipeline empty and sel=0: bypass. out_valid = in_valid, in_ready = out_ready, y = f(a..h) combinationally, no state change.
  - Pipeline empty and sel=1: pipeline path; out_valid = 0.
- y is forced to all-zero whenever out_valid = 0.
- sel may change on any cycle. Results always leave in input-acceptance order.
- Reset: all v[k] = 0, all data registers = 0, xfer_count = 0.
  - Results after reset: out_valid = 0; y = 0.
  - in_ready after reset follows the empty-pipeline rules above: out_ready if sel=0, 1 if sel=1.
- Reset asserted mid-stream discards all in-flight results; nothing is presented on the cycle after the reset edge.

## Timing
- Bypass latency: 0 cycles; purely combinational from in_valid/a..h to out_valid/y, and from out_ready to in_ready.
- Pipelined latency: a handshake at edge N gives out_valid high after edge N+DEPTH-1, i.e. DEPTH cycles, with no stall.
- Pipelined throughput: 1 result per cycle while out_ready is held high.
- Full condition: all DEPTH stages valid and out_ready = 0. Then in_ready = 0.
- Simultaneous accept and drain when full and out_ready = 1: both complete in the same cycle and occupancy is unchanged.
- Draining after sel 1->0 with out_ready = 1: takes the number of valid stages in cycles.
  - The first bypass transfer can occur in the cycle after the last pipelined result is taken.
- Combinational path out_ready -> in_ready exists in both modes.

## Configuration
- LFP_COUNT_EN defined:
  - xfer_count increments by 1 on every output handshake, in both modes.
  - It saturates at 16'hFFFF and clears on rst.
- LFP_COUNT_EN undefined:
  - xfer_count is tied to 16'h0000.
  - No counter logic is instantiated.

## Test plan
- Bypass with WIDTH=8, sel=0, in_valid=1, out_ready=1, a=FF, b=0F, g=F0, h=30, all other operands 00 -> same cycle: y=CF, out_valid=1, in_ready=1.
- Same operands with e=FF, f=00 -> y=C0, which exercises the (~e|f) mask.
- DEPTH=2, sel=1, out_ready=1:
  - Stimulus: 4 back-to-back operand sets.
  - Response: out_valid first high two cycles after the first accept; then 4 consecutive results in order; in_ready stays 1.
- DEPTH=2, sel=1, out_ready=0:
  - Stimulus: 3 offers.
  - Response: 2 accepted, in_ready=0 on the third; no result changes while stalled.
  - Then raise out_ready: all results emerge in order, and the third operand set is accepted in the same cycle as the first drain.
- Mode change: two results in flight, switch sel to 0 -> in_ready=0 until both pipelined results are taken, then bypass resumes with the correct y.
- Reset and counter:
  - Assert rst with a full pipeline -> next cycle out_valid=0, y=00.
  - With LFP_COUNT_EN: 5 output handshakes -> xfer_count=5; rst -> xfer_count=0.
